axis_write_burst: RTL and testbench

//  Stream-to-AXI write engine, successor of the fixed single-burst writer. Packs DATA_WIDTH words into
//  AXI_DATA_WIDTH beats, splits a transfer into bursts clipped at MAX_BURST and 4 KiB boundaries, and keeps
//  up to OUTSTANDING bursts of AW ahead of W. Supports one-shot or circular (auto-repeat) mode. Configured

---
 rtl/axis_write_burst.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axis_write_burst.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_write_burst.sv
// Stream-to-AXI write engine: packs stream words into AXI beats, splits transfers into 4 KiB-safe bursts.
// AW runs ahead of W by up to OUTSTANDING bursts. Define AXIS_WRITE_BRESP_EN to add B-channel tracking.
module axis_write_burst #(
  parameter int CFG_ID         = 1,
  parameter int CFG_ADDR       = 23,
  parameter int CFG_DATA       = 24,
  parameter int CFG_AWIDTH     = 5,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_BURST      = 16,
  parameter int OUTSTANDING    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_AWIDTH-1:0]     cfg_addr,
  input  logic [CFG_DWIDTH-1:0]     cfg_data,
  input  logic                      cfg_valid,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wlast,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
`ifdef AXIS_WRITE_BRESP_EN
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
`endif
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      busy,
  output logic                      done
);
  localparam int RATIO      = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int BEAT_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam int PTR_W      = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int DEPTH      = 2 ** PTR_W;
  localparam int CNT_W      = $clog2(RATIO + 1);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    CONFIG = 5'b00010,
    RUN    = 5'b00100,
    DRAIN  = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                cfg_cnt_q, cfg_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] start_q, start_d;
  logic [CFG_DWIDTH-1:0]     len_q, len_d;
  logic                      circ_q, circ_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [CFG_DWIDTH-1:0]     aw_rem_q, aw_rem_d;
  logic                      awvalid_q, awvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_LEN_WIDTH-1:0]  awlen_q, awlen_d;
  logic [AXI_LEN_WIDTH-1:0]  fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]            fcnt_q, fcnt_d;
  logic [AXI_LEN_WIDTH-1:0]  wbeat_q, wbeat_d;
  logic [AXI_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [CNT_W-1:0]          pk_cnt_q, pk_cnt_d;
`ifdef AXIS_WRITE_BRESP_EN
  logic [CFG_DWIDTH-1:0]     issued_q, issued_d, bcnt_q, bcnt_d;
  logic                      err_q, err_d;
`endif

  logic                      run, aw_hs, w_full, w_valid, w_last, w_hs, s_hs;
  logic [12:0]               to_4k;
  logic [CFG_DWIDTH-1:0]     beats, beats_4k;
  logic [CNT_W-1:0]          base_cnt;

  assign run     = (state_q == RUN);
  assign aw_hs   = awvalid_q & axi_awready;
  assign w_full  = (pk_cnt_q == CNT_W'(RATIO));
  assign w_valid = run & w_full & (fcnt_q != '0);
  assign w_last  = w_valid & (wbeat_q == fifo_mem_q[rd_ptr_q]);
  assign w_hs    = w_valid & axi_wready;
  assign ready   = run & (~w_full | w_hs);
  assign s_hs    = valid & ready;

  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_wdata   = pack_q;
  assign axi_wvalid  = w_valid;
  assign axi_wlast   = w_last;
  assign busy        = (state_q == RUN) | (state_q == DRAIN);
  assign done        = (state_q == DONE);
`ifdef AXIS_WRITE_BRESP_EN
  assign axi_bready  = busy;
`endif

  always_comb begin
    // Beats allowed in the next burst: clipped by MAX_BURST, what is left, and the next 4 KiB page.
    to_4k    = 13'h1000 - {1'b0, aw_addr_q[11:0]};
    beats_4k = CFG_DWIDTH'(to_4k >> BEAT_SHIFT);
    beats    = CFG_DWIDTH'(MAX_BURST);
    if (aw_rem_q < beats) beats = aw_rem_q;
    if (beats_4k < beats) beats = beats_4k;
  end

  always_comb begin
    state_d   = state_q;
    cfg_cnt_d = cfg_cnt_q;
    start_d   = start_q;
    len_d     = len_q;
    circ_d    = circ_q;
    aw_addr_d = aw_addr_q;
    aw_rem_d  = aw_rem_q;
    awvalid_d = awvalid_q & ~aw_hs;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    wr_ptr_d  = wr_ptr_q + PTR_W'(aw_hs);
    rd_ptr_d  = rd_ptr_q + PTR_W'(w_hs & w_last);
    fcnt_d    = fcnt_q + (PTR_W+1)'(aw_hs) - (PTR_W+1)'(w_hs & w_last);
    wbeat_d   = w_hs ? (w_last ? '0 : wbeat_q + 1'b1) : wbeat_q;
    pack_d    = pack_q;
    base_cnt  = w_hs ? '0 : pk_cnt_q;
    pk_cnt_d  = base_cnt;
    if (s_hs) begin
      for (int i = 0; i < RATIO; i++) begin
        if (CNT_W'(i) == base_cnt) pack_d[i*DATA_WIDTH +: DATA_WIDTH] = data;
      end
      pk_cnt_d = base_cnt + CNT_W'(1);
    end
`ifdef AXIS_WRITE_BRESP_EN
    issued_d = issued_q + CFG_DWIDTH'(aw_hs);
    bcnt_d   = bcnt_q;
    err_d    = err_q;
    if (axi_bvalid && busy) begin
      bcnt_d = bcnt_q + 1'b1;
      if (axi_bresp != 2'b00) err_d = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_ADDR) && cfg_data == CFG_DWIDTH'(CFG_ID)) begin
          state_d   = CONFIG;
          cfg_cnt_d = '0;
          pk_cnt_d  = '0;
`ifdef AXIS_WRITE_BRESP_EN
          err_d     = 1'b0;
`endif
        end
      end
      CONFIG: begin
        if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_DATA)) begin
          cfg_cnt_d = cfg_cnt_q + 1'b1;
          case (cfg_cnt_q)
            2'd0:    start_d = cfg_data[AXI_ADDR_WIDTH-1:0] & ~AXI_ADDR_WIDTH'((1 << BEAT_SHIFT) - 1);
            2'd1:    len_d   = cfg_data;
            default: begin
              circ_d    = cfg_data[0];
              aw_addr_d = start_q;
              aw_rem_d  = len_q;
              state_d   = (len_q == '0) ? IDLE : RUN;
`ifdef AXIS_WRITE_BRESP_EN
              issued_d  = '0;
              bcnt_d    = '0;
`endif
            end
          endcase
        end
      end
      RUN: begin
        // Address/remaining advance when the burst is presented; its length enters the FIFO on handshake.
        if (!awvalid_q && aw_rem_q != '0 && fcnt_q < (PTR_W+1)'(OUTSTANDING)) begin
          awvalid_d = 1'b1;
          awaddr_d  = aw_addr_q;
          awlen_d   = AXI_LEN_WIDTH'(beats - 1'b1);
          aw_addr_d = aw_addr_q + (AXI_ADDR_WIDTH'(beats) << BEAT_SHIFT);
          aw_rem_d  = aw_rem_q - beats;
        end
        if (aw_rem_q == '0 && !awvalid_q && fcnt_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
`ifdef AXIS_WRITE_BRESP_EN
        if (bcnt_q == issued_q) begin
          if (circ_q && !err_q) begin
            state_d   = RUN;
            aw_addr_d = start_q;
            aw_rem_d  = len_q;
            issued_d  = '0;
            bcnt_d    = '0;
          end else begin
            state_d = DONE;
          end
        end
`else
        if (circ_q) begin
          state_d   = RUN;
          aw_addr_d = start_q;
          aw_rem_d  = len_q;
        end else begin
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cfg_cnt_q <= '0;
      start_q   <= '0;
      len_q     <= '0;
      circ_q    <= 1'b0;
      aw_addr_q <= '0;
      aw_rem_q  <= '0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      wbeat_q   <= '0;
      pack_q    <= '0;
      pk_cnt_q  <= '0;
`ifdef AXIS_WRITE_BRESP_EN
      issued_q  <= '0;
      bcnt_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cfg_cnt_q <= cfg_cnt_d;
      start_q   <= start_d;
      len_q     <= len_d;
      circ_q    <= circ_d;
      aw_addr_q <= aw_addr_d;
      aw_rem_q  <= aw_rem_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      wbeat_q   <= wbeat_d;
      pack_q    <= pack_d;
      pk_cnt_q  <= pk_cnt_d;
`ifdef AXIS_WRITE_BRESP_EN
      issued_q  <= issued_d;
      bcnt_q    <= bcnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) fifo_mem_q[wr_ptr_q] <= awlen_q;
  end
endmodule

// File: tb/tb_axis_write_burst.sv
// Randomized scoreboard bench for axis_write_burst: a transfer-level model predicts AW bursts and W beats,
// a monitor pops and compares on every handshake. Define AXIS_WRITE_BRESP_EN to also exercise the B channel.
module tb_axis_write_burst;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_awvalid, axi_awready;
  logic [63:0] axi_wdata;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [31:0] data;
  logic        valid, ready, busy, done;
`ifdef AXIS_WRITE_BRESP_EN
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
`endif

  axis_write_burst dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
`ifdef AXIS_WRITE_BRESP_EN
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
`endif
    .data(data), .valid(valid), .ready(ready), .busy(busy), .done(done)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [63:0] d; logic last; } w_t;
  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [31:0] stream_q[$];
  aw_t         e_aw;
  w_t          e_w;

  int n_checks = 0, n_fail = 0;
  int aw_hs_cnt = 0, w_hs_cnt = 0, done_cnt = 0, b_cnt = 0, b_at_done = 0;
  int aw_mode = 0, w_mode = 0;  // 0 random, 1 forced high, 2 forced low
  logic done_prev = 1'b0;

  // Transfer-level model: walk the byte address in 4 KiB-clipped bursts, two stream words per beat.
  task automatic plan(input logic [31:0] addr, input int len, input int aw_reps, input int w_reps,
                      input bit ramp);
    logic [31:0] a, w0, w1;
    int rem, b, room, k;
    k = 0;
    for (int r = 0; r < aw_reps; r++) begin
      a = addr & ~32'h7;
      rem = len;
      while (rem > 0) begin
        room = (4096 - int'(a[11:0])) / 8;
        b = (rem < 16) ? rem : 16;
        if (room < b) b = room;
        exp_aw.push_back('{a, 8'(b - 1)});
        if (r < w_reps) begin
          for (int j = 0; j < b; j++) begin
            w0 = ramp ? 32'(k) : $urandom;
            w1 = ramp ? 32'(k + 1) : $urandom;
            k += 2;
            stream_q.push_back(w0);
            stream_q.push_back(w1);
            exp_w.push_back('{{w1, w0}, j == b - 1});
          end
        end
        a += 32'(b * 8);
        rem -= b;
      end
    end
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic configure(input logic [31:0] addr, input int len, input logic [31:0] mode);
    cfg_write(5'd23, 32'd1);
    cfg_write(5'd24, addr);
    cfg_write(5'd24, 32'(len));
    cfg_write(5'd24, mode);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic wait_idle(input int target, input string name);
    int cyc = 0;
    while ((done_cnt != target || exp_aw.size() != 0 || exp_w.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (done_cnt != target || exp_aw.size() != 0 || exp_w.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: done_cnt %0d required %0d, aw left %0d, w left %0d, busy %0b required 0",
               name, done_cnt, target, exp_aw.size(), exp_w.size(), busy);
    end else begin
      $display("ok   %s complete, done_cnt %0d", name, done_cnt);
    end
  endtask

  // Ready generators
  initial begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      axi_awready = (aw_mode == 1) ? 1'b1 : (aw_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      axi_wready  = (w_mode == 1)  ? 1'b1 : (w_mode == 2)  ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Stream source with random valid gaps
  initial begin
    logic acc;
    valid = 1'b0;
    data  = '0;
    forever begin
      @(negedge clk);
      acc = valid && ready;
      @(posedge clk); #1;
      if (acc) void'(stream_q.pop_front());
      if (stream_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        valid = 1'b1;
        data  = stream_q[0];
      end else begin
        valid = 1'b0;
      end
    end
  end

`ifdef AXIS_WRITE_BRESP_EN
  logic [1:0] resp_q[$];
  initial begin
    logic bacc, wl;
    int pend;
    pend = 0;
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      bacc = axi_bvalid && axi_bready;
      wl   = axi_wvalid && axi_wready && axi_wlast;
      @(posedge clk); #1;
      if (!rst) begin
        pend = 0;
      end else begin
        if (wl) pend++;
        if (bacc) begin
          pend--;
          b_cnt++;
          if (resp_q.size() > 0) void'(resp_q.pop_front());
        end
      end
      if (pend > 0 && $urandom_range(0, 1) != 0) begin
        axi_bvalid = 1'b1;
        axi_bresp  = (resp_q.size() > 0) ? resp_q[0] : 2'b00;
      end else begin
        axi_bvalid = 1'b0;
      end
    end
  end
`endif

  // Monitor: pops the scoreboard on every AW/W handshake and tracks done pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (axi_awvalid && axi_awready) begin
        aw_hs_cnt++;
        n_checks++;
        if (exp_aw.size() == 0) begin
          n_fail++;
          $display("FAIL aw_unexpected: got addr %h len %0d, required no AW", axi_awaddr, axi_awlen);
        end else begin
          e_aw = exp_aw.pop_front();
          if (e_aw.addr !== axi_awaddr || e_aw.len !== axi_awlen) begin
            n_fail++;
            $display("FAIL aw: got addr %h len %0d, required addr %h len %0d",
                     axi_awaddr, axi_awlen, e_aw.addr, e_aw.len);
          end else begin
            $display("AW  addr %h len %0d", axi_awaddr, axi_awlen);
          end
        end
      end
      if (axi_wvalid && axi_wready) begin
        w_hs_cnt++;
        n_checks++;
        if (exp_w.size() == 0) begin
          n_fail++;
          $display("FAIL w_unexpected: got data %h last %0b, required no W", axi_wdata, axi_wlast);
        end else begin
          e_w = exp_w.pop_front();
          if (e_w.d !== axi_wdata || e_w.last !== axi_wlast) begin
            n_fail++;
            $display("FAIL w: got data %h last %0b, required data %h last %0b",
                     axi_wdata, axi_wlast, e_w.d, e_w.last);
          end else begin
            $display("W   data %h last %0b", axi_wdata, axi_wlast);
          end
        end
      end
      if (done) begin
        n_checks++;
        if (done_prev) begin
          n_fail++;
          $display("FAIL done_width: got done high 2 cycles, required 1-cycle pulse");
        end
        done_cnt++;
        b_at_done = b_cnt;
      end
    end
    done_prev = done;
  end

  initial begin
    int base_aw, base_w, base_done, len, cyc;
    logic [31:0] addr;
    rst = 1'b0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {59'd0, axi_awvalid, axi_wvalid, ready, busy, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: packing order, single burst, wlast on beat 8
    plan(32'h1000, 8, 1, 1, 1'b1);
    configure(32'h1000, 8, 32'd0);
    wait_idle(1, "t1_oneshot");

    // 2: 4 KiB split
    plan(32'h0FF0, 8, 1, 1, 1'b0);
    configure(32'h0FF0, 8, 32'd0);
    wait_idle(2, "t2_4k_split");

    // 3: AW run-ahead with W stalled
    base_aw = aw_hs_cnt; base_w = w_hs_cnt;
    aw_mode = 1; w_mode = 2;
    plan(32'h3000, 40, 1, 1, 1'b0);
    configure(32'h3000, 40, 32'd0);
    repeat (40) @(negedge clk);
    check("t3_aw_ahead", 64'(aw_hs_cnt - base_aw), 64'd3);
    check("t3_w_stalled", 64'(w_hs_cnt - base_w), 64'd0);
    aw_mode = 0; w_mode = 0;
    wait_idle(3, "t3_release");

    // Random transfers near page boundaries, unaligned start addresses
    for (int t = 0; t < 4; t++) begin
      addr = 32'h0001_0000 + 32'(t * 32'h2000) + 32'($urandom_range(0, 4095));
      len  = $urandom_range(1, 40);
      plan(addr, len, 1, 1, 1'b0);
      configure(addr, len, 32'd0);
      wait_idle(4 + t, "rand_transfer");
    end

    // 6: id mismatch and zero length do nothing
    base_aw = aw_hs_cnt; base_done = done_cnt;
    cfg_write(5'd23, 32'd2);
    cfg_write(5'd24, 32'h5000);
    cfg_write(5'd24, 32'd4);
    cfg_write(5'd24, 32'd0);
    repeat (20) @(negedge clk);
    check("t6_mismatch_aw", 64'(aw_hs_cnt - base_aw), 64'd0);
    check("t6_mismatch_idle", {62'd0, busy, done_cnt != base_done}, 64'd0);
    configure(32'h5000, 0, 32'd0);
    repeat (20) @(negedge clk);
    check("t6_len0_aw", 64'(aw_hs_cnt - base_aw), 64'd0);
    check("t6_len0_idle", {62'd0, busy, done_cnt != base_done}, 64'd0);

`ifdef AXIS_WRITE_BRESP_EN
    // 5: error on second response ends even a circular transfer after all B are counted
    base_done = done_cnt;
    cyc = b_cnt;
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
    plan(32'h8000, 40, 1, 1, 1'b0);
    configure(32'h8000, 40, 32'd1);
    wait_idle(base_done + 1, "t5_bresp_err");
    check("t5_b_before_done", 64'(b_at_done - cyc), 64'd3);
`endif

    // 4: circular mode repeats until reset, no done
    base_done = done_cnt;
    plan(32'h2000, 4, 4, 3, 1'b0);
    configure(32'h2000, 4, 32'd1);
    cyc = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_circ_left", 64'(exp_aw.size() + exp_w.size()), 64'd0);
    check("t4_circ_busy_nodone", {62'd0, busy, done_cnt != base_done}, 64'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t4_reset_outputs", {59'd0, axi_awvalid, axi_wvalid, ready, busy, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
